// File: rtl/ksa_pulse_result_capture.sv
// Receiver for the pulse-coded adder: synchronizes GCLK/sum/cout pulses, frames one
// word per GCLK window, flags glitch/race/overflow and queues words in a small FIFO.
module ksa_pulse_result_capture #(
  parameter int NBITS        = 4,
  parameter int FIFO_DEPTH   = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int SKIP_WINDOWS = 0
) (
  input  logic             SCLK_Pad,
  input  logic             rst_Pad,
  input  logic             GCLK_Pad,
  input  logic [NBITS-1:0] sum_Pad,
  input  logic             cout_Pad,
  output logic [NBITS:0]   out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      win_count,
  output logic             glitch_err,
  output logic             race_err,
  output logic             ovf_err,
  input  logic             err_clr
);

  localparam int W   = NBITS + 2;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int SKW = $clog2(SKIP_WINDOWS + 1) + 1;
  localparam logic [SKW-1:0] SKIP_L = SKW'(SKIP_WINDOWS);
  localparam logic [CW-1:0]  FULL_L = CW'(FIFO_DEPTH);

  // Bit layout of every synchronizer stage: {gclk, cout, sum[NBITS-1:0]}
  logic [W-1:0]     sync_q [SYNC_STAGES];
  logic [W-1:0]     sync_d [SYNC_STAGES];
  logic [W-1:0]     prev_q, prev_d;
  logic [NBITS:0]   acc_q, acc_d;
  logic [SKW-1:0]   skip_cnt_q, skip_cnt_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NBITS:0]   out_data_q, out_data_d;
  logic [15:0]      win_count_q, win_count_d;
  logic             glitch_q, glitch_d, race_q, race_d, ovf_q, ovf_d;
  logic [NBITS:0]   mem_q [FIFO_DEPTH];

  logic [W-1:0]     rise;
  logic             gclk_rise;
  logic [NBITS:0]   data_rise;
  logic [NBITS:0]   word;
  logic             skip_done, full, push_req, push, pop;

  always_comb begin
    sync_d[0] = {GCLK_Pad, cout_Pad, sum_Pad};
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  always_comb begin
    prev_d    = sync_q[SYNC_STAGES-1];
    rise      = sync_q[SYNC_STAGES-1] & ~prev_q;
    gclk_rise = rise[W-1];
    data_rise = rise[NBITS:0];
    // A data pulse coincident with GCLK belongs to the window being closed
    word      = acc_q | data_rise;
    acc_d     = gclk_rise ? '0 : word;

    skip_done  = (skip_cnt_q >= SKIP_L);
    skip_cnt_d = skip_cnt_q;
    if (gclk_rise && !skip_done) skip_cnt_d = skip_cnt_q + 1'b1;

    win_count_d = win_count_q + {15'd0, gclk_rise};

    full     = (cnt_q == FULL_L);
    push_req = gclk_rise && skip_done;
    // Fullness is judged on the registered count, so a same-cycle pop never makes room
    push     = push_req && !full;
    pop      = (cnt_q != '0) && out_ready;

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q + CW'(push) - CW'(pop);

    // Registered head: forward the incoming word when it lands in the head slot
    if (cnt_d == '0)                      out_data_d = '0;
    else if (push && wr_ptr_q == rd_ptr_d) out_data_d = word;
    else                                  out_data_d = mem_q[rd_ptr_d];

    glitch_d = (glitch_q & ~err_clr) | (!gclk_rise && |(acc_q & data_rise));
    race_d   = (race_q   & ~err_clr) | (gclk_rise && |data_rise);
    ovf_d    = (ovf_q    & ~err_clr) | (push_req && full);
  end

  always_ff @(posedge SCLK_Pad or posedge rst_Pad) begin
    if (rst_Pad) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q      <= '0;
      acc_q       <= '0;
      skip_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      win_count_q <= '0;
      glitch_q    <= 1'b0;
      race_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
      prev_q      <= prev_d;
      acc_q       <= acc_d;
      skip_cnt_q  <= skip_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      win_count_q <= win_count_d;
      glitch_q    <= glitch_d;
      race_q      <= race_d;
      ovf_q       <= ovf_d;
    end
  end

  // Storage needs no reset: entries are only visible through the pointers
  always_ff @(posedge SCLK_Pad) begin
    if (push) mem_q[wr_ptr_q] <= word;
  end

  assign out_data   = out_data_q;
  assign out_valid  = (cnt_q != '0);
  assign win_count  = win_count_q;
  assign glitch_err = glitch_q;
  assign race_err   = race_q;
  assign ovf_err    = ovf_q;

endmodule

// File: tb/tb_ksa_pulse_result_capture.sv
// Directed bench for ksa_pulse_result_capture; a second instance covers window skipping.
module tb_ksa_pulse_result_capture;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       gclk = 1'b0;
  logic [3:0] sum = '0;
  logic       cout = 1'b0;
  logic       rdy = 1'b0;
  logic       clr = 1'b0;

  logic [4:0]  d_data;
  logic        d_valid, d_glitch, d_race, d_ovf;
  logic [15:0] d_win;
  logic [4:0]  s_data;
  logic        s_valid, s_glitch, s_race, s_ovf;
  logic [15:0] s_win;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  ksa_pulse_result_capture #(.NBITS(4), .FIFO_DEPTH(8), .SYNC_STAGES(2), .SKIP_WINDOWS(0)) dut (
    .SCLK_Pad(clk), .rst_Pad(rst), .GCLK_Pad(gclk), .sum_Pad(sum), .cout_Pad(cout),
    .out_data(d_data), .out_valid(d_valid), .out_ready(rdy), .win_count(d_win),
    .glitch_err(d_glitch), .race_err(d_race), .ovf_err(d_ovf), .err_clr(clr));

  ksa_pulse_result_capture #(.NBITS(4), .FIFO_DEPTH(8), .SYNC_STAGES(2), .SKIP_WINDOWS(20)) dut_skip (
    .SCLK_Pad(clk), .rst_Pad(rst), .GCLK_Pad(gclk), .sum_Pad(sum), .cout_Pad(cout),
    .out_data(s_data), .out_valid(s_valid), .out_ready(rdy), .win_count(s_win),
    .glitch_err(s_glitch), .race_err(s_race), .ovf_err(s_ovf), .err_clr(clr));

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle-high pulse followed by one idle cycle, so repeats give clean edges
  task automatic pulse(input logic g, input logic [3:0] s, input logic c);
    gclk = g; sum = s; cout = c;
    @(negedge clk);
    gclk = 1'b0; sum = '0; cout = 1'b0;
    @(negedge clk);
  endtask

  task automatic pop_one();
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    tick(1);
    chk_cnt++;
    if ({d_valid, d_data, d_win, d_glitch, d_race, d_ovf} !== 25'd0)
      $display("FAIL reset_state: got valid=%0b data=%b win=%0d err=%b%b%b, want all zero",
               d_valid, d_data, d_win, d_glitch, d_race, d_ovf);
    else pass_cnt++;
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_basic_word();
    pulse(0, 4'b1000, 0);
    pulse(0, 4'b0010, 0);
    pulse(0, 4'b0000, 1);
    pulse(1, 4'b0000, 0);
    chk_cnt++;
    if (d_valid !== 1'b0) $display("FAIL latency_early: got out_valid=%b, want 0 after 2nd edge", d_valid);
    else pass_cnt++;
    tick(1);
    chk_cnt++;
    if (d_valid !== 1'b1) $display("FAIL latency_valid: got out_valid=%b, want 1 after 3rd edge", d_valid);
    else pass_cnt++;
    chk_cnt++;
    if (d_data !== 5'b11010) $display("FAIL basic_word: got %b, want 11010", d_data);
    else pass_cnt++;
    chk_cnt++;
    if (d_win !== 16'd1) $display("FAIL basic_win: got %0d, want 1", d_win);
    else pass_cnt++;
    pop_one();
    chk_cnt++;
    if ({d_valid, d_data} !== 6'd0) $display("FAIL basic_pop: got valid=%b data=%b, want 0/00000", d_valid, d_data);
    else pass_cnt++;
  endtask

  task automatic test_glitch();
    pulse(0, 4'b0100, 0);
    pulse(0, 4'b0100, 0);
    pulse(1, 4'b0000, 0);
    tick(1);
    chk_cnt++;
    if (d_data !== 5'b00100) $display("FAIL glitch_word: got %b, want 00100", d_data);
    else pass_cnt++;
    chk_cnt++;
    if (d_glitch !== 1'b1) $display("FAIL glitch_set: got %b, want 1", d_glitch);
    else pass_cnt++;
    pop_one();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk_cnt++;
    if (d_glitch !== 1'b0) $display("FAIL glitch_clr: got %b, want 0", d_glitch);
    else pass_cnt++;
    // Second pulse's rise is registered on the edge where err_clr is also high
    pulse(0, 4'b0100, 0);
    pulse(0, 4'b0100, 0);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk_cnt++;
    if (d_glitch !== 1'b1) $display("FAIL glitch_set_wins: got %b, want 1", d_glitch);
    else pass_cnt++;
    pulse(1, 4'b0000, 0);
    tick(1);
    pop_one();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  task automatic test_race();
    chk_cnt++;
    if ({d_valid, d_glitch, d_race} !== 3'b000)
      $display("FAIL race_pre: got valid=%b glitch=%b race=%b, want 000", d_valid, d_glitch, d_race);
    else pass_cnt++;
    pulse(1, 4'b0010, 0);
    pulse(1, 4'b0000, 0);
    tick(1);
    chk_cnt++;
    if (d_data !== 5'b00010) $display("FAIL race_word: got %b, want 00010", d_data);
    else pass_cnt++;
    chk_cnt++;
    if (d_race !== 1'b1) $display("FAIL race_set: got %b, want 1", d_race);
    else pass_cnt++;
    chk_cnt++;
    if (d_glitch !== 1'b0) $display("FAIL race_noglitch: got %b, want 0", d_glitch);
    else pass_cnt++;
    pop_one();
    chk_cnt++;
    if ({d_valid, d_data} !== 6'b100000) $display("FAIL race_next: got valid=%b data=%b, want 1/00000", d_valid, d_data);
    else pass_cnt++;
    pop_one();
    chk_cnt++;
    if (d_valid !== 1'b0) $display("FAIL race_drain: got valid=%b, want 0", d_valid);
    else pass_cnt++;
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  task automatic test_overflow();
    logic [3:0] v;
    rdy = 1'b0;
    for (int i = 0; i < 9; i++) begin
      v = 4'(i + 1);
      pulse(0, v, 0);
      pulse(1, 4'b0000, 0);
    end
    tick(1);
    chk_cnt++;
    if (d_ovf !== 1'b1) $display("FAIL ovf_set: got %b, want 1", d_ovf);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      chk_cnt++;
      if ({d_valid, d_data} !== {1'b1, 5'(i + 1)})
        $display("FAIL ovf_drain_%0d: got valid=%b data=%b, want 1/%b", i, d_valid, d_data, 5'(i + 1));
      else pass_cnt++;
      pop_one();
    end
    chk_cnt++;
    if (d_valid !== 1'b0) $display("FAIL ovf_empty: got valid=%b, want 0 (9th word dropped)", d_valid);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    rdy = 1'b0;
    repeat (3) pulse(1, 4'b0000, 0);
    tick(1);
    pulse(0, 4'b0001, 0);
    #2 rst = 1'b1;
    #1;
    chk_cnt++;
    if ({d_valid, d_win, d_ovf} !== 18'd0)
      $display("FAIL reset_async: got valid=%b win=%0d ovf=%b, want 0/0/0", d_valid, d_win, d_ovf);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    tick(1);
    pulse(0, 4'b0100, 0);
    pulse(1, 4'b0000, 0);
    tick(1);
    chk_cnt++;
    if ({d_valid, d_data, d_win} !== {1'b1, 5'b00100, 16'd1})
      $display("FAIL reset_recover: got valid=%b data=%b win=%0d, want 1/00100/1", d_valid, d_data, d_win);
    else pass_cnt++;
    pop_one();
  endtask

  task automatic test_skip();
    do_reset();
    repeat (20) pulse(1, 4'b0000, 0);
    tick(1);
    chk_cnt++;
    if ({s_valid, s_win} !== {1'b0, 16'd20}) $display("FAIL skip_empty: got valid=%b win=%0d, want 0/20", s_valid, s_win);
    else pass_cnt++;
    pulse(0, 4'b0001, 0);
    pulse(1, 4'b0000, 0);
    tick(1);
    chk_cnt++;
    if ({s_valid, s_data, s_win} !== {1'b1, 5'b00001, 16'd21})
      $display("FAIL skip_word: got valid=%b data=%b win=%0d, want 1/00001/21", s_valid, s_data, s_win);
    else pass_cnt++;
    pop_one();
    chk_cnt++;
    if (s_valid !== 1'b0) $display("FAIL skip_single: got valid=%b, want 0 after one pop", s_valid);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic_word();
    test_glitch();
    test_race();
    test_overflow();
    test_reset_mid();
    test_skip();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
